// File: rtl/gmii_rx_pkg.sv
// gmii_rx_pkg: shared constants for the GMII receive deframer
// Holds the FSM state type, preamble/SFD bytes, record kinds and lengths,
// and the CRC-32 constants plus a 32-bit bit-reverse helper.
package gmii_rx_pkg;
   typedef enum logic [2:0] {S_IDLE, S_PRE, S_HDR, S_PHDR, S_VID, S_AUD, S_FCS, S_DROP} state_t;
   localparam logic [7:0]  PRE_BYTE    = 8'h55;
   localparam logic [7:0]  SFD_BYTE    = 8'hD5;
   localparam logic [7:0]  KIND_VID    = 8'h01;
   localparam logic [7:0]  KIND_AUD    = 8'h02;
   localparam logic [3:0]  HDR_LAST    = 4'd13;
   localparam logic [2:0]  VID_LAST    = 3'd5;
   localparam logic [2:0]  AUD_LAST    = 3'd2;
   localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
   localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
   localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;
   function automatic logic [31:0] bitrev32(input logic [31:0] x);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[i] = x[31-i];
      return r;
   endfunction
endpackage

// File: rtl/crc32_d8.sv
// crc32_d8: one-byte-per-cycle reflected CRC-32 update
// Ports: crc_i current register, d_i data byte (LSB first on the wire), crc_o updated register.
module crc32_d8
   import gmii_rx_pkg::*;
(
   input  logic [31:0] crc_i,
   input  logic [7:0]  d_i,
   output logic [31:0] crc_o
);
   localparam logic [31:0] POLY_R = bitrev32(CRC_POLY);
   always_comb begin
      crc_o = crc_i;
      for (int i = 0; i < 8; i++) crc_o = {1'b0, crc_o[31:1]} ^ ((crc_o[0] ^ d_i[i]) ? POLY_R : 32'd0);
   end
endmodule

// File: rtl/gmii_rx.sv
// gmii_rx: GMII receive deframer writing video/audio records into rx FIFOs
// Ports: rx_clk/sys_rst_n clock and async active-low reset; rx_dv/rx_er/rxd GMII pins;
// id node id; vfifo_*/afifo_* record FIFO write side; frame_done/frame_err end-of-frame
// pulses; drop_cnt saturating count of errored frames.
// Build option: CRC_CHECK_EN adds an FCS residue check; without it FCS bytes are only counted.
module gmii_rx
   import gmii_rx_pkg::*;
#(
   parameter logic [15:0] ETHERTYPE = 16'h88B5,
   parameter logic [10:0] VID_MAX   = 11'd200,
   parameter logic [10:0] AUD_MAX   = 11'd32,
   parameter int          CNT_W     = 16
) (
   input  logic             rx_clk,
   input  logic             sys_rst_n,
   input  logic             rx_dv,
   input  logic             rx_er,
   input  logic [7:0]       rxd,
   input  logic             id,
   output logic [47:0]      vfifo_din,
   output logic             vfifo_wr_en,
   input  logic             vfifo_full,
   output logic [23:0]      afifo_din,
   output logic             afifo_wr_en,
   input  logic             afifo_full,
   output logic             frame_done,
   output logic             frame_err,
   output logic [CNT_W-1:0] drop_cnt
);
   state_t state_q, state_d;
   logic dv_q, er_q, vid_q, vid_d, ovf_q, ovf_d, vwr_q, vwr_d, awr_q, awr_d;
   logic done_q, done_d, err_q, err_d, body, full, crc_ok;
   logic [7:0] d_q;
   logic [3:0] cnt_q, cnt_d;
   logic [39:0] sr_q, sr_d;
   logic [10:0] rec_q, rec_d, lim;
   logic [47:0] vdin_q, vdin_d, word;
   logic [23:0] adin_q, adin_d;
   logic [CNT_W-1:0] drop_q, drop_d;
   logic [2:0] last;
   // word: the last six received bytes, newest in the low byte
   assign word = {sr_q, d_q};
   assign lim  = vid_q ? VID_MAX : AUD_MAX;
   assign last = state_q == S_VID ? VID_LAST : AUD_LAST;
   assign full = state_q == S_VID ? vfifo_full : afifo_full;
   assign body = state_q inside {S_HDR, S_PHDR, S_VID, S_AUD, S_FCS};
`ifdef CRC_CHECK_EN
   logic [31:0] crc_q, crc_d, crc_nx;
   crc32_d8 u_crc (.crc_i(crc_q), .d_i(d_q), .crc_o(crc_nx));
   // CRC covers dst through FCS; it is re-seeded every preamble byte
   assign crc_d  = state_q == S_PRE ? CRC_INIT : (body && dv_q) ? crc_nx : crc_q;
   assign crc_ok = bitrev32(crc_q) == CRC_RESIDUE;
   always_ff @(posedge rx_clk or negedge sys_rst_n)
      if (!sys_rst_n) crc_q <= CRC_INIT;
      else crc_q <= crc_d;
`else
   assign crc_ok = 1'b1;
`endif
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sr_d    = {sr_q[31:0], d_q};
      rec_d   = rec_q;
      vid_d   = vid_q;
      ovf_d   = ovf_q;
      vdin_d  = vdin_q;
      adin_d  = adin_q;
      vwr_d   = 1'b0;
      awr_d   = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      if (state_q == S_DROP) begin
         state_d = dv_q ? S_DROP : S_IDLE;
         err_d   = !dv_q;
      end else if (dv_q && er_q) begin
         state_d = S_DROP;
      end else if (!dv_q) begin
         // only FCS with exactly four bytes and no overflow ends cleanly; PRE/IDLE end silently
         done_d  = body && state_q == S_FCS && cnt_q == 4'd4 && !ovf_q && crc_ok;
         err_d   = body && !done_d;
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: state_d = d_q == PRE_BYTE ? S_PRE : S_DROP;
            S_PRE: begin
               cnt_d   = '0;
               ovf_d   = 1'b0;
               state_d = d_q == SFD_BYTE ? S_HDR : d_q == PRE_BYTE ? S_PRE : S_DROP;
            end
            S_HDR: begin
               cnt_d = cnt_q == HDR_LAST ? '0 : cnt_q + 4'd1;
               if (cnt_q == HDR_LAST) state_d = word[15:0] == ETHERTYPE ? S_PHDR : S_DROP;
            end
            S_PHDR: begin
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == 4'd0 && d_q != {7'd0, id}) state_d = S_DROP;
               if (cnt_q == 4'd1) begin
                  vid_d = d_q == KIND_VID;
                  if (d_q != KIND_VID && d_q != KIND_AUD) state_d = S_DROP;
               end
               if (cnt_q == 4'd3) begin
                  cnt_d   = '0;
                  rec_d   = word[10:0];
                  state_d = (word[15:0] == 16'd0 || word[15:0] > {5'd0, lim}) ? S_DROP : vid_q ? S_VID : S_AUD;
               end
            end
            S_VID, S_AUD: begin
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == {1'b0, last}) begin
                  // a record hitting a full FIFO is dropped but the frame keeps parsing
                  cnt_d   = '0;
                  rec_d   = rec_q - 11'd1;
                  state_d = rec_q == 11'd1 ? S_FCS : state_q;
                  ovf_d   = ovf_q | full;
                  vwr_d   = state_q == S_VID && !full;
                  awr_d   = state_q == S_AUD && !full;
                  vdin_d  = vwr_d ? word : vdin_q;
                  adin_d  = awr_d ? word[23:0] : adin_q;
               end
            end
            S_FCS: begin
               cnt_d   = cnt_q + 4'd1;
               state_d = cnt_q == 4'd4 ? S_DROP : S_FCS;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end
   assign drop_d = (err_d && !(&drop_q)) ? drop_q + 1'b1 : drop_q;
   always_ff @(posedge rx_clk or negedge sys_rst_n)
      if (!sys_rst_n) begin
         dv_q    <= 1'b0;
         er_q    <= 1'b0;
         d_q     <= '0;
         state_q <= S_IDLE;
         cnt_q   <= '0;
         sr_q    <= '0;
         rec_q   <= '0;
         vid_q   <= 1'b0;
         ovf_q   <= 1'b0;
         vdin_q  <= '0;
         adin_q  <= '0;
         vwr_q   <= 1'b0;
         awr_q   <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         drop_q  <= '0;
      end else begin
         dv_q    <= rx_dv;
         er_q    <= rx_er;
         d_q     <= rxd;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sr_q    <= sr_d;
         rec_q   <= rec_d;
         vid_q   <= vid_d;
         ovf_q   <= ovf_d;
         vdin_q  <= vdin_d;
         adin_q  <= adin_d;
         vwr_q   <= vwr_d;
         awr_q   <= awr_d;
         done_q  <= done_d;
         err_q   <= err_d;
         drop_q  <= drop_d;
      end
   assign vfifo_din   = vdin_q;
   assign vfifo_wr_en = vwr_q;
   assign afifo_din   = adin_q;
   assign afifo_wr_en = awr_q;
   assign frame_done  = done_q;
   assign frame_err   = err_q;
   assign drop_cnt    = drop_q;
endmodule

// File: tb/tb_gmii_rx.sv
// tb_gmii_rx: scoreboard bench for gmii_rx with directed frames
module tb_gmii_rx;
   logic clk = 1'b0, rst_n = 1'b0, rx_dv = 1'b0, rx_er = 1'b0, id = 1'b1, vfull = 1'b0, afull = 1'b0;
   logic [7:0] rxd = 8'h00;
   logic [47:0] vfifo_din;
   logic [23:0] afifo_din;
   logic vfifo_wr_en, afifo_wr_en, frame_done, frame_err;
   logic [15:0] drop_cnt;
   always #4 clk = ~clk;
   gmii_rx dut (
      .rx_clk(clk), .sys_rst_n(rst_n), .rx_dv(rx_dv), .rx_er(rx_er), .rxd(rxd), .id(id),
      .vfifo_din(vfifo_din), .vfifo_wr_en(vfifo_wr_en), .vfifo_full(vfull),
      .afifo_din(afifo_din), .afifo_wr_en(afifo_wr_en), .afifo_full(afull),
      .frame_done(frame_done), .frame_err(frame_err), .drop_cnt(drop_cnt)
   );
   typedef struct {logic err; int drop;} ev_t;
   logic [47:0] vq[$];
   logic [23:0] aq[$];
   ev_t evq[$];
   logic [7:0] body[$];
   int checks = 0, errors = 0, drop_exp = 0;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask
   task automatic expect_end(input logic err);
      if (err) drop_exp++;
      evq.push_back('{err, drop_exp});
   endtask
   always @(negedge clk) if (rst_n) begin
      ev_t e;
      if (vfifo_wr_en) begin
         if (vq.size() == 0) begin
            checks++; errors++;
            $display("FAIL vfifo_wr: unexpected write got %h required none", vfifo_din);
         end else chk("vfifo_din", 64'(vfifo_din), 64'(vq.pop_front()));
      end
      if (afifo_wr_en) begin
         if (aq.size() == 0) begin
            checks++; errors++;
            $display("FAIL afifo_wr: unexpected write got %h required none", afifo_din);
         end else chk("afifo_din", 64'(afifo_din), 64'(aq.pop_front()));
      end
      if (frame_done && frame_err) begin
         checks++; errors++;
         $display("FAIL frame_pulse: got done=1 err=1 required one of them");
      end else if (frame_done || frame_err) begin
         if (evq.size() == 0) begin
            checks++; errors++;
            $display("FAIL frame_pulse: unexpected done=%0d err=%0d required none", frame_done, frame_err);
         end else begin
            e = evq.pop_front();
            chk("frame_err", 64'(frame_err), 64'(e.err));
            chk("drop_cnt", 64'(drop_cnt), 64'(e.drop));
         end
      end
   end
   task automatic drv(input logic dv, input logic [7:0] b, input logic er, input logic f);
      @(posedge clk);
      #1;
      rx_dv = dv; rxd = b; rx_er = er; vfull = f;
   endtask
   function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r = c;
      for (int b = 0; b < 8; b++) r = (r[0] ^ d[b]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction
   function automatic logic [47:0] vrec(input logic [10:0] v, input logic [10:0] h, input logic [23:0] t);
      return {1'b0, v, 1'b0, h, t};
   endfunction
   task automatic hdr(input logic [15:0] typ, input logic [7:0] idb, input logic [7:0] kind, input logic [15:0] n);
      body.delete();
      for (int i = 0; i < 6; i++) body.push_back(8'hFF);
      for (int i = 0; i < 6; i++) body.push_back(8'(8'h10 + i));
      body.push_back(typ[15:8]); body.push_back(typ[7:0]);
      body.push_back(idb); body.push_back(kind);
      body.push_back(n[15:8]); body.push_back(n[7:0]);
   endtask
   task automatic add_vid(input logic [47:0] w);
      for (int i = 5; i >= 0; i--) body.push_back(w[i*8 +: 8]);
   endtask
   task automatic add_aud(input logic [23:0] w);
      for (int i = 2; i >= 0; i--) body.push_back(w[i*8 +: 8]);
   endtask
   task automatic add_fcs();
      logic [31:0] c = 32'hFFFFFFFF;
      foreach (body[i]) c = crc_upd(c, body[i]);
      c = ~c;
      body.push_back(c[7:0]); body.push_back(c[15:8]); body.push_back(c[23:16]); body.push_back(c[31:24]);
   endtask
   task automatic send(input int er_at, input int cut_at, input int f_lo, input int f_hi, input int gap);
      repeat (7) drv(1'b1, 8'h55, 1'b0, 1'b0);
      drv(1'b1, 8'hD5, 1'b0, 1'b0);
      for (int i = 0; i < body.size() && i != cut_at; i++) drv(1'b1, body[i], i == er_at, i >= f_lo && i <= f_hi);
      repeat (gap) drv(1'b0, 8'h00, 1'b0, 1'b0);
   endtask
   task automatic drain(input string name);
      int n = 0;
      while ((vq.size() + aq.size() + evq.size()) != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      checks++;
      if ((vq.size() + aq.size() + evq.size()) != 0) begin
         errors++;
         $display("FAIL %s: outstanding v=%0d a=%0d ev=%0d required 0", name, vq.size(), aq.size(), evq.size());
         vq.delete(); aq.delete(); evq.delete();
      end
   endtask
   task automatic chk_zero(input string tag);
      chk({tag, "_vdin"}, 64'(vfifo_din), 64'd0);
      chk({tag, "_vwr"}, 64'(vfifo_wr_en), 64'd0);
      chk({tag, "_adin"}, 64'(afifo_din), 64'd0);
      chk({tag, "_awr"}, 64'(afifo_wr_en), 64'd0);
      chk({tag, "_done"}, 64'(frame_done), 64'd0);
      chk({tag, "_err"}, 64'(frame_err), 64'd0);
      chk({tag, "_drop"}, 64'(drop_cnt), 64'd0);
   endtask
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   initial begin
      logic [47:0] r1, r2, r3;
      logic [23:0] a;
      r1 = vrec(11'h016, 11'h0DC, 24'h123456);
      r2 = vrec(11'h016, 11'h0DD, 24'h654321);
      r3 = vrec(11'h7FF, 11'h7FF, 24'hFFFFFF);
      repeat (3) @(posedge clk);
      #1;
      chk_zero("reset");
      rst_n = 1'b1;
      // clean video frame, two records
      hdr(16'h88B5, 8'h01, 8'h01, 16'd2); add_vid(r1); add_vid(r2); add_fcs();
      vq.push_back(r1); vq.push_back(r2); expect_end(1'b0);
      send(-1, -1, -1, -1, 4); drain("video2");
      // audio at the count limit
      hdr(16'h88B5, 8'h01, 8'h02, 16'd32);
      for (int i = 0; i < 32; i++) begin
         a = {11'(i + 5), 4'd0, 8'(8'hA0 + i), 1'(i % 2)};
         add_aud(a); aq.push_back(a);
      end
      add_fcs(); expect_end(1'b0);
      send(-1, -1, -1, -1, 4); drain("audio32");
      // audio one over the limit
      hdr(16'h88B5, 8'h01, 8'h02, 16'd33);
      for (int i = 0; i < 4; i++) add_aud(24'h123456);
      add_fcs(); expect_end(1'b1);
      send(-1, -1, -1, -1, 4); drain("audio33");
      // wrong EtherType
      hdr(16'h0800, 8'h01, 8'h01, 16'd1); add_vid(r1); add_fcs(); expect_end(1'b1);
      send(-1, -1, -1, -1, 4); drain("ethertype");
      // id mismatch
      hdr(16'h88B5, 8'h00, 8'h01, 16'd1); add_vid(r1); add_fcs(); expect_end(1'b1);
      send(-1, -1, -1, -1, 4); drain("id");
      // unknown kind
      hdr(16'h88B5, 8'h01, 8'h03, 16'd1); add_vid(r1); add_fcs(); expect_end(1'b1);
      send(-1, -1, -1, -1, 4); drain("kind");
      // video count zero
      hdr(16'h88B5, 8'h01, 8'h01, 16'd0); add_fcs(); expect_end(1'b1);
      send(-1, -1, -1, -1, 4); drain("count0");
      // FIFO full while record 2 of 3 completes
      hdr(16'h88B5, 8'h01, 8'h01, 16'd3); add_vid(r1); add_vid(r2); add_vid(r3); add_fcs();
      vq.push_back(r1); vq.push_back(r3); expect_end(1'b1);
      send(-1, -1, 26, 33, 4); drain("overflow");
      // rx_er inside record 1
      hdr(16'h88B5, 8'h01, 8'h01, 16'd2); add_vid(r1); add_vid(r2); add_fcs(); expect_end(1'b1);
      send(20, -1, -1, -1, 4); drain("rx_er");
      // rx_dv falls inside record 2
      hdr(16'h88B5, 8'h01, 8'h01, 16'd2); add_vid(r1); add_vid(r2); add_fcs();
      vq.push_back(r1); expect_end(1'b1);
      send(-1, 27, -1, -1, 4); drain("truncated");
      // extra byte after FCS
      hdr(16'h88B5, 8'h01, 8'h02, 16'd1); add_aud(24'hABCDEF); add_fcs(); body.push_back(8'h00);
      aq.push_back(24'hABCDEF); expect_end(1'b1);
      send(-1, -1, -1, -1, 4); drain("extra");
      // payload bit flipped after the FCS was computed
      hdr(16'h88B5, 8'h01, 8'h01, 16'd1); add_vid(r2); add_fcs(); body[20] = body[20] ^ 8'h04;
      vq.push_back(r2 ^ 48'h0000_0400_0000);
`ifdef CRC_CHECK_EN
      expect_end(1'b1);
`else
      expect_end(1'b0);
`endif
      send(-1, -1, -1, -1, 4); drain("crc_flip");
      // back-to-back frames with a single idle cycle
      hdr(16'h88B5, 8'h01, 8'h02, 16'd1); add_aud(24'h111111); add_fcs();
      aq.push_back(24'h111111); expect_end(1'b0);
      send(-1, -1, -1, -1, 1);
      hdr(16'h88B5, 8'h01, 8'h02, 16'd1); add_aud(24'h222222); add_fcs();
      aq.push_back(24'h222222); expect_end(1'b0);
      send(-1, -1, -1, -1, 4); drain("b2b");
      // preamble abandoned before SFD: no pulse
      repeat (3) drv(1'b1, 8'h55, 1'b0, 1'b0);
      repeat (4) drv(1'b0, 8'h00, 1'b0, 1'b0);
      drain("pre_abort");
      // reset in the middle of record 2
      hdr(16'h88B5, 8'h01, 8'h01, 16'd2); add_vid(r1); add_vid(r2); add_fcs();
      vq.push_back(r1);
      repeat (7) drv(1'b1, 8'h55, 1'b0, 1'b0);
      drv(1'b1, 8'hD5, 1'b0, 1'b0);
      for (int i = 0; i < 28; i++) drv(1'b1, body[i], 1'b0, 1'b0);
      chk("pre_rst_vq", 64'(vq.size()), 64'd0);
      #1 rst_n = 1'b0;
      #1 chk_zero("midrst");
      rx_dv = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      drop_exp = 0;
      hdr(16'h88B5, 8'h01, 8'h01, 16'd1); add_vid(r3); add_fcs();
      vq.push_back(r3); expect_end(1'b0);
      send(-1, -1, -1, -1, 4); drain("after_rst");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
